multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk_i  input  1  clock, all state updates on rising edge.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 op_i  input  7  opcode field of the instruction register.
REQ-005 funct3_i  input  3  funct3 field, decoded as ALU operation select.
REQ-006 funct7_i  input  1  funct7 bit 5, decoded as ALU operation select.
REQ-007 zero_flag_i  input  1  ALU zero flag.
REQ-008 mem_ready_i  input  1  memory access complete this cycle.
REQ-009 mem_req_o  output  1  memory access request.
REQ-010 mem_write_o  output  1  store strobe.
REQ-011 adr_src_o  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-012 ir_write_o  output  1  instruction register load.
REQ-013 pc_write_o  output  1  PC load.
REQ-014 reg_write_o  output  1  register file write.
REQ-015 alu_src_a_o  output  2  00=PC, 01=OldPC, 10=rs1.
REQ-016 alu_src_b_o  output  2  00=rs2, 01=imm, 10=constant 4.
REQ-017 alu_op_o  output  2  00=add, 01=sub/compare, 10=funct-decoded.
REQ-018 result_src_o  output  2  00=ALUOut, 01=memory data, 10=ALU result.
REQ-019 imm_src_o  output  2  00=I, 01=S, 10=B, 11=J.
REQ-020 illegal_o  output  1  one-cycle pulse on unsupported opcode.
REQ-021 instr_done_o  output  1  one-cycle pulse when an instruction retires.

Function
REQ-022 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL and BEQ; all outputs are a combinational function of state, op_i, zero_flag_i and mem_ready_i.
REQ-023 Any output not listed for a state SHALL be 0.
REQ-024 FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10; ir_write=pc_write=mem_ready_i; state holds until mem_ready_i=1, then goes to DECODE.
REQ-025 DECODE: a=01, b=01, alu_op=00 (branch target precompute); next state by op_i:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1101111 -> JAL
- 1100011 -> BEQ
- any other opcode -> FETCH, with illegal_o=1 and instr_done_o=1.
REQ-026 MEMADR: a=10, b=01, alu_op=00; next state MEMREAD if op_i=0000011, else MEMWRITE.
REQ-027 MEMREAD: mem_req=1, adr_src=1, result_src=00; holds until mem_ready_i, then goes to MEMWB.
REQ-028 MEMWB: result_src=01, reg_write=1, instr_done=1; next state FETCH.
REQ-029 MEMWRITE: mem_req=1, mem_write=1 (level, held while waiting), adr_src=1; on mem_ready_i goes to FETCH with instr_done=1.
REQ-030 EXECR: a=10, b=00, alu_op=10; next state ALUWB. EXECI: a=10, b=01, alu_op=10; next state ALUWB.
REQ-031 ALUWB: result_src=00, reg_write=1, instr_done=1; next state FETCH.
REQ-032 JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1; next state ALUWB.
REQ-033 BEQ: a=10, b=00, alu_op=01, result_src=00, pc_write=zero_flag_i, instr_done=1; next state FETCH.
REQ-034 imm_src_o SHALL be decoded from op_i in every state: I-type/load=00, store=01, branch=10, jal=11, otherwise 00.
REQ-035 Latency at mem_ready_i=1 every cycle, in cycles: lw=5, sw=4, R/I=4, jal=4, beq=3.
REQ-036 Each wait cycle SHALL add exactly one cycle, and mem_write_o, pc_write_o and ir_write_o SHALL never pulse more than once per access.
REQ-037 op_i changes outside DECODE/MEMADR SHALL NOT alter state transitions.

Reset
REQ-038 With rst_i high at a clock edge, state SHALL become FETCH regardless of current state, including mid-wait in MEMREAD/MEMWRITE.
REQ-039 While rst_i=1, mem_req, mem_write, ir_write, pc_write, reg_write, illegal and instr_done SHALL be forced to 0.
REQ-040 After reset the first cycle SHALL be FETCH with mem_req_o=1.

Verification
REQ-041 lw (0000011), mem_ready_i=1 throughout -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; reg_write=1 only in cycle 5, result_src=01; instr_done pulses cycle 5.
REQ-042 sw (0100011), mem_ready_i low for 3 MEMWRITE cycles -> mem_write_o high for 4 consecutive cycles; exactly one instr_done pulse.
REQ-043 beq with zero_flag_i=1 -> pc_write=1 in BEQ; with zero_flag_i=0 -> pc_write=0; both return to FETCH after 3 cycles.
REQ-044 op_i=1111111 -> illegal_o=1 and instr_done=1 in DECODE, next state FETCH, reg_write/mem_write never asserted.
REQ-045 rst_i asserted during a MEMREAD wait -> next cycle FETCH, strobes 0 during reset, no reg_write afterward for the aborted load.
REQ-046 jal (1101111) -> pc_write in JAL cycle, reg_write with result_src=00 in ALUWB, imm_src_o=11 throughout.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV-style datapath control FSM
module multicycle_controller (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_i,
    input  logic       zero_flag_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_write_o,
    output logic       adr_src_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] result_src_o,
    output logic [1:0] imm_src_o,
    output logic       illegal_o,
    output logic       instr_done_o
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ
    } state_t;

    state_t state;

    // funct fields are consumed by the ALU decoder downstream, not here
    logic unused_funct;
    assign unused_funct = ^{funct3_i, funct7_i};

    logic op_known;
    assign op_known = (op_i == OP_LOAD) || (op_i == OP_STORE) || (op_i == OP_REG) ||
                      (op_i == OP_IMM)  || (op_i == OP_JAL)   || (op_i == OP_BEQ);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (mem_ready_i) state <= S_DECODE;
                S_DECODE: begin
                    case (op_i)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_REG:            state <= S_EXECR;
                        OP_IMM:            state <= S_EXECI;
                        OP_JAL:            state <= S_JAL;
                        OP_BEQ:            state <= S_BEQ;
                        default:           state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state <= (op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (mem_ready_i) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (mem_ready_i) state <= S_FETCH;
                S_EXECR:    state <= S_ALUWB;
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                S_BEQ:      state <= S_FETCH;
                default:    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req_o    = 1'b0;
        mem_write_o  = 1'b0;
        adr_src_o    = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        result_src_o = 2'b00;
        illegal_o    = 1'b0;
        instr_done_o = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req_o    = 1'b1;
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                ir_write_o   = mem_ready_i;
                pc_write_o   = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_a_o  = 2'b01;
                alu_src_b_o  = 2'b01;
                illegal_o    = !op_known;
                instr_done_o = !op_known;
            end
            S_MEMADR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
            end
            S_MEMREAD: begin
                mem_req_o = 1'b1;
                adr_src_o = 1'b1;
            end
            S_MEMWB: begin
                result_src_o = 2'b01;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_o    = 1'b1;
                mem_write_o  = 1'b1;
                adr_src_o    = 1'b1;
                instr_done_o = mem_ready_i;
            end
            S_EXECR: begin
                alu_src_a_o = 2'b10;
                alu_op_o    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                alu_op_o    = 2'b10;
            end
            S_ALUWB: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            S_JAL: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                pc_write_o  = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_o  = 2'b10;
                alu_op_o     = 2'b01;
                pc_write_o   = zero_flag_i;
                instr_done_o = 1'b1;
            end
            default: ;
        endcase

        // Strobes are squashed during reset so an aborted access has no side effects
        if (rst_i) begin
            mem_req_o    = 1'b0;
            mem_write_o  = 1'b0;
            ir_write_o   = 1'b0;
            pc_write_o   = 1'b0;
            reg_write_o  = 1'b0;
            illegal_o    = 1'b0;
            instr_done_o = 1'b0;
        end
    end

    always_comb begin
        case (op_i)
            OP_STORE: imm_src_o = 2'b01;
            OP_BEQ:   imm_src_o = 2'b10;
            OP_JAL:   imm_src_o = 2'b11;
            default:  imm_src_o = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed-vector bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [6:0] op_i;
    logic [2:0] funct3_i;
    logic       funct7_i;
    logic       zero_flag_i;
    logic       mem_ready_i;
    logic       mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o;
    logic [1:0] alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, imm_src_o;
    logic       illegal_o, instr_done_o;

    int checks = 0;
    int failures = 0;

    multicycle_controller dut (
        .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
        .zero_flag_i(zero_flag_i), .mem_ready_i(mem_ready_i),
        .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .adr_src_o(adr_src_o),
        .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .reg_write_o(reg_write_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
        .result_src_o(result_src_o), .imm_src_o(imm_src_o),
        .illegal_o(illegal_o), .instr_done_o(instr_done_o)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RR = 7'b0110011;
    localparam logic [6:0] RI = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    // Field order: mem_req mem_write adr_src ir_write pc_write reg_write illegal done | a b aluop rs imm
    function automatic logic [17:0] pk(input logic mreq, mw, adr, irw, pcw, rw, ill, done,
                                       input logic [1:0] a, b, aop, rs, imm);
        return {mreq, mw, adr, irw, pcw, rw, ill, done, a, b, aop, rs, imm};
    endfunction

    logic [17:0] obs;
    assign obs = {mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o,
                  illegal_o, instr_done_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                  result_src_o, imm_src_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [6:0] op, input logic z, input logic rdy,
                       input logic [17:0] exp);
        op_i = op;
        zero_flag_i = z;
        mem_ready_i = rdy;
        #1;
        check(tag, {14'd0, obs}, {14'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; op_i = LW; funct3_i = 3'd0; funct7_i = 1'b0;
        zero_flag_i = 1'b0; mem_ready_i = 1'b1;
        @(posedge clk); #1;
        cyc("reset_hold",  LW, 0, 1, pk(0,0,0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b00));
        rst_i = 1'b0;

        // lw, no wait: 5 cycles
        cyc("lw_fetch",    LW, 0, 1, pk(1,0,0,1,1,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b00));
        cyc("lw_decode",   LW, 0, 1, pk(0,0,0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00,2'b00));
        cyc("lw_memadr",   LW, 0, 1, pk(0,0,0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00,2'b00));
        cyc("lw_memread",  LW, 0, 1, pk(1,0,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00));
        cyc("lw_memwb",    LW, 0, 1, pk(0,0,0,0,0,1,0,1, 2'b00,2'b00,2'b00,2'b01,2'b00));

        // sw with a fetch wait and 3 memwrite waits; mem_write held 4 cycles, one done
        cyc("sw_fetchwait", SW, 0, 0, pk(1,0,0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b01));
        cyc("sw_fetch",    SW, 0, 1, pk(1,0,0,1,1,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b01));
        cyc("sw_decode",   SW, 0, 1, pk(0,0,0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00,2'b01));
        cyc("sw_memadr",   SW, 0, 1, pk(0,0,0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00,2'b01));
        for (int i = 0; i < 3; i++)
            cyc("sw_wait",  SW, 0, 0, pk(1,1,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01));
        cyc("sw_memwrite", SW, 0, 1, pk(1,1,1,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b01));

        // R-type
        cyc("r_fetch",     RR, 0, 1, pk(1,0,0,1,1,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b00));
        cyc("r_decode",    RR, 0, 1, pk(0,0,0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00,2'b00));
        cyc("r_execr",     RR, 0, 1, pk(0,0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00));
        cyc("r_aluwb",     RR, 0, 1, pk(0,0,0,0,0,1,0,1, 2'b00,2'b00,2'b00,2'b00,2'b00));

        // I-type
        cyc("i_fetch",     RI, 0, 1, pk(1,0,0,1,1,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b00));
        cyc("i_decode",    RI, 0, 1, pk(0,0,0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00,2'b00));
        cyc("i_execi",     RI, 0, 1, pk(0,0,0,0,0,0,0,0, 2'b10,2'b01,2'b10,2'b00,2'b00));
        cyc("i_aluwb",     RI, 0, 1, pk(0,0,0,0,0,1,0,1, 2'b00,2'b00,2'b00,2'b00,2'b00));

        // jal
        cyc("jal_fetch",   JL, 0, 1, pk(1,0,0,1,1,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b11));
        cyc("jal_decode",  JL, 0, 1, pk(0,0,0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00,2'b11));
        cyc("jal_jal",     JL, 0, 1, pk(0,0,0,0,1,0,0,0, 2'b01,2'b10,2'b00,2'b00,2'b11));
        cyc("jal_aluwb",   JL, 0, 1, pk(0,0,0,0,0,1,0,1, 2'b00,2'b00,2'b00,2'b00,2'b11));

        // beq taken then not taken
        cyc("beqt_fetch",  BQ, 1, 1, pk(1,0,0,1,1,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b10));
        cyc("beqt_decode", BQ, 1, 1, pk(0,0,0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00,2'b10));
        cyc("beqt_beq",    BQ, 1, 1, pk(0,0,0,0,1,0,0,1, 2'b10,2'b00,2'b01,2'b00,2'b10));
        cyc("beqn_fetch",  BQ, 0, 1, pk(1,0,0,1,1,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b10));
        cyc("beqn_decode", BQ, 0, 1, pk(0,0,0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00,2'b10));
        cyc("beqn_beq",    BQ, 0, 1, pk(0,0,0,0,0,0,0,1, 2'b10,2'b00,2'b01,2'b00,2'b10));

        // illegal opcode
        cyc("ill_fetch",   BAD, 0, 1, pk(1,0,0,1,1,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b00));
        cyc("ill_decode",  BAD, 0, 1, pk(0,0,0,0,0,0,1,1, 2'b01,2'b01,2'b00,2'b00,2'b00));

        // lw with memread wait; opcode changes mid-wait must not redirect the FSM
        cyc("lw2_fetch",   LW, 0, 1, pk(1,0,0,1,1,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b00));
        cyc("lw2_decode",  LW, 0, 1, pk(0,0,0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00,2'b00));
        cyc("lw2_memadr",  LW, 0, 1, pk(0,0,0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00,2'b00));
        cyc("lw2_wait",    SW, 0, 0, pk(1,0,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01));
        cyc("lw2_memread", BAD, 0, 1, pk(1,0,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00));
        cyc("lw2_memwb",   LW, 0, 1, pk(0,0,0,0,0,1,0,1, 2'b00,2'b00,2'b00,2'b01,2'b00));

        // reset during memread wait aborts the load
        cyc("lw3_fetch",   LW, 0, 1, pk(1,0,0,1,1,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b00));
        cyc("lw3_decode",  LW, 0, 1, pk(0,0,0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00,2'b00));
        cyc("lw3_memadr",  LW, 0, 1, pk(0,0,0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00,2'b00));
        cyc("lw3_wait",    LW, 0, 0, pk(1,0,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00));
        rst_i = 1'b1;
        cyc("lw3_rst",     LW, 0, 1, pk(0,0,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00));
        rst_i = 1'b0;
        cyc("post_fetchw", LW, 0, 0, pk(1,0,0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b00));
        cyc("post_fetch",  LW, 0, 1, pk(1,0,0,1,1,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b00));
        cyc("post_decode", LW, 0, 1, pk(0,0,0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00,2'b00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
